// File: rtl/uart_loader_pkg.sv
// Shared types, default parameters and sizing helpers for the UART bank loader.
package uart_loader_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FULL  = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam int DEF_N_BANKS        = 4;
    localparam int DEF_DEPTH          = 10;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_BYTE_W         = 8;
    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_RD_LATENCY     = 1;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int count_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index n items; never narrower than 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_bank_loader_byte_packer.sv
// Rising-edge byte accept plus little-endian lane packing into one RAM word.
module byte_packer
    import uart_loader_pkg::*;
#(
    parameter int BYTE_W         = DEF_BYTE_W,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int DATA_W         = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              accept,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    localparam int IW = idx_w(BYTES_PER_WORD);
    localparam logic [IW-1:0] LAST_LANE = IW'(BYTES_PER_WORD - 1);

    logic                                  valid_d;
    logic [IW-1:0]                         byte_idx;
    logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] lanes;

    // Edge history survives clear so a held-high valid is not re-accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_d <= 1'b0;
        else        valid_d <= rx_valid;
    end

    assign accept = rx_valid & ~valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= '0;
            lanes      <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
            end else if (accept && enable) begin
                lanes[byte_idx] <= rx_data;
                if (byte_idx == LAST_LANE) begin
                    byte_idx   <= '0;
                    word_valid <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

    assign word = DATA_W'(lanes);

endmodule

// File: rtl/uart_bank_loader.sv
// Fills N_BANKS BRAMs from the UART byte stream, then sweeps them in lock-step
// to stream one row per cycle, single-shot or looping.
module uart_bank_loader
    import uart_loader_pkg::*;
#(
    parameter int N_BANKS        = DEF_N_BANKS,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int BYTE_W         = DEF_BYTE_W,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int RD_LATENCY     = DEF_RD_LATENCY,
    parameter int AW             = $clog2(DEPTH),
    localparam int CW            = count_w(N_BANKS * DEPTH * BYTES_PER_WORD)
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [BYTE_W-1:0]           i_rx_data,
    input  logic                        i_rx_valid,
    input  logic                        i_clear,
    input  logic                        i_rd_start,
    input  logic                        i_rd_en,
    input  logic                        i_rd_loop,
    input  logic [N_BANKS*DATA_W-1:0]   i_rdata,
    output logic [N_BANKS-1:0]          o_we,
    output logic [AW-1:0]               o_addr,
    output logic [DATA_W-1:0]           o_wdata,
    output logic                        o_rd_valid,
    output logic [AW-1:0]               o_rd_addr,
    output logic                        o_rd_done,
    output logic                        o_loaded,
    output logic                        o_overflow,
    output logic [CW-1:0]               o_byte_count
);

    localparam int BW = idx_w(N_BANKS);
    localparam int DW = idx_w(RD_LATENCY);
    localparam logic [BW-1:0] LAST_BANK  = BW'(N_BANKS - 1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(RD_LATENCY - 1);

    state_t              state, state_nx;
    logic [BW-1:0]       bank_idx;
    logic [AW-1:0]       wr_addr, rd_addr;
    logic [DW-1:0]       drain_cnt;
    logic                accept, word_valid;
    logic                write, last_write, issue, last_issue, drain_end;
    logic [RD_LATENCY:1]           vld_pipe;
    logic [RD_LATENCY:1][AW-1:0]   addr_pipe;

    // Row data goes straight from the banks to the multiplier, not through here.
    logic unused_rdata;
    assign unused_rdata = ^i_rdata;

    byte_packer #(
        .BYTE_W         (BYTE_W),
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .DATA_W         (DATA_W)
    ) u_packer (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .clear      (i_clear),
        .enable     (state == S_LOAD),
        .rx_data    (i_rx_data),
        .rx_valid   (i_rx_valid),
        .accept     (accept),
        .word_valid (word_valid),
        .word       (o_wdata)
    );

    assign write      = word_valid && (state == S_LOAD) && !i_clear;
    assign last_write = write && (bank_idx == LAST_BANK) && (wr_addr == LAST_ADDR);
    assign issue      = (state == S_READ) && i_rd_en && !i_clear;
    assign last_issue = issue && (rd_addr == LAST_ADDR);
    assign drain_end  = (state == S_DRAIN) && (drain_cnt == LAST_DRAIN);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_LOAD;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        o_we     = '0;
        if (write) o_we[bank_idx] = 1'b1;
        o_addr = ((state == S_READ) || (state == S_DRAIN)) ? rd_addr : wr_addr;
        if (i_clear) begin
            state_nx = S_LOAD;
        end else begin
            case (state)
                S_LOAD:  if (last_write)              state_nx = S_FULL;
                S_FULL:  if (i_rd_start)              state_nx = S_READ;
                S_READ:  if (last_issue && !i_rd_loop) state_nx = S_DRAIN;
                S_DRAIN: if (drain_end)               state_nx = S_FULL;
                default:                              state_nx = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bank_idx     <= '0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            drain_cnt    <= '0;
            o_byte_count <= '0;
            o_overflow   <= 1'b0;
            o_loaded     <= 1'b0;
            o_rd_done    <= 1'b0;
        end else if (i_clear) begin
            bank_idx     <= '0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            drain_cnt    <= '0;
            o_byte_count <= '0;
            o_overflow   <= 1'b0;
            o_loaded     <= 1'b0;
            o_rd_done    <= 1'b0;
        end else begin
            o_rd_done <= drain_end;
            if (accept) begin
                if (state == S_LOAD) o_byte_count <= o_byte_count + 1'b1;
                else                 o_overflow   <= 1'b1;
            end
            if (write) begin
                if (wr_addr == LAST_ADDR) begin
                    wr_addr  <= '0;
                    bank_idx <= (bank_idx == LAST_BANK) ? '0 : bank_idx + 1'b1;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            if (last_write) o_loaded <= 1'b1;
            if ((state == S_FULL) && i_rd_start) rd_addr <= '0;
            if (issue) rd_addr <= last_issue ? '0 : rd_addr + 1'b1;
            if (state == S_DRAIN) drain_cnt <= drain_end ? '0 : drain_cnt + 1'b1;
        end
    end

    // Issue tag travels alongside the BRAM read so it lines up with i_rdata.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else if (i_clear) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[1]  <= issue;
            addr_pipe[1] <= rd_addr;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign o_rd_valid = vld_pipe[RD_LATENCY];
    assign o_rd_addr  = addr_pipe[RD_LATENCY];

endmodule

// File: tb/tb_uart_bank_loader.sv
// Directed bench: load, overflow, clear, single-shot and looping sweeps with a BRAM model.
module tb_uart_bank_loader;
    import uart_loader_pkg::*;

    localparam int NB = 4, DP = 10, DW = 32;

    logic         clk = 1'b0;
    logic         rst_n, rx_valid, clear, rd_start, rd_en, rd_loop;
    logic [7:0]   rx_data;
    logic [NB*DW-1:0] rdata = '0;
    logic [NB-1:0] we;
    logic [3:0]   addr, rd_addr;
    logic [DW-1:0] wdata;
    logic         rd_valid, rd_done, loaded, overflow;
    logic [7:0]   byte_count;

    int passed = 0, total = 0;

    always #5 clk = ~clk;

    uart_bank_loader #(
        .N_BANKS(NB), .DEPTH(DP), .DATA_W(DW), .BYTE_W(8),
        .BYTES_PER_WORD(4), .RD_LATENCY(1)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_clear(clear), .i_rd_start(rd_start), .i_rd_en(rd_en), .i_rd_loop(rd_loop),
        .i_rdata(rdata), .o_we(we), .o_addr(addr), .o_wdata(wdata),
        .o_rd_valid(rd_valid), .o_rd_addr(rd_addr), .o_rd_done(rd_done),
        .o_loaded(loaded), .o_overflow(overflow), .o_byte_count(byte_count)
    );

    // BRAM model: write captured mid-cycle, 1-cycle registered read.
    logic [DW-1:0] mem [NB][DP];
    logic [3:0]    addr_s = '0;
    int            wr_cnt = 0;
    logic [NB-1:0] last_we = '0;
    logic [3:0]    last_addr = '0;
    logic [DW-1:0] last_data = '0;

    always @(negedge clk) begin
        addr_s = addr;
        if (we != '0) begin
            for (int b = 0; b < NB; b++) if (we[b] && addr < DP) mem[b][addr] = wdata;
            wr_cnt++;
            last_we   = we;
            last_addr = addr;
            last_data = wdata;
        end
    end

    always @(posedge clk)
        for (int b = 0; b < NB; b++)
            rdata[b*DW +: DW] <= (addr_s < DP) ? mem[b][addr_s] : '0;

    function automatic logic [31:0] word_of(input int n);
        return {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_data = b; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    initial begin
        int base, nval, amis, dmis, first, lastv, done_cnt, done_c;
        logic gap_vld;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; clear = 1'b0;
        rd_start = 1'b0; rd_en = 1'b0; rd_loop = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {we, addr, wdata, rd_valid, rd_addr, rd_done, loaded, overflow, byte_count}, 64'd0);
        check("reset_state", 64'(dut.state), 64'(S_LOAD));
        rst_n = 1'b1;

        // Reset in the middle of a load
        for (int i = 1; i <= 7; i++) send_byte(8'(i));
        check("count_7", 64'(byte_count), 64'd7);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outs", {we, addr, wdata, rd_valid, rd_addr, rd_done, loaded, overflow, byte_count}, 64'd0);
        check("midrst_state", 64'(dut.state), 64'(S_LOAD));
        check("midrst_idx", 64'(dut.u_packer.byte_idx), 64'd0);
        rst_n = 1'b1;
        base = wr_cnt;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        check("first_wr_cnt", 64'(wr_cnt - base), 64'd1);
        check("first_wr_we", 64'(last_we), 64'b0001);
        check("first_wr_addr", 64'(last_addr), 64'd0);
        check("first_wr_data", 64'(last_data), 64'h44332211);

        // Full load of 160 bytes
        pulse_clear();
        check("clr_count", 64'(byte_count), 64'd0);
        base = wr_cnt;
        for (int i = 0; i < 159; i++) send_byte(8'(i));
        @(negedge clk); rx_data = 8'h9F; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        check("last_we", 64'(we), 64'b1000);
        check("last_addr", 64'(addr), 64'd9);
        check("last_wdata", 64'(wdata), 64'h9F9E9D9C);
        check("loaded_not_yet", 64'(loaded), 64'd0);
        @(negedge clk);
        check("loaded_rise", 64'(loaded), 64'd1);
        check("full_wr_cnt", 64'(wr_cnt - base), 64'd40);
        check("full_count", 64'(byte_count), 64'd160);
        check("full_state", 64'(dut.state), 64'(S_FULL));
        check("mem_b0a0", 64'(mem[0][0]), 64'h03020100);
        check("mem_b1a0", 64'(mem[1][0]), 64'h2B2A2928);
        check("mem_b3a9", 64'(mem[3][9]), 64'h9F9E9D9C);
        amis = 0;
        for (int k = 0; k < NB; k++)
            for (int a = 0; a < DP; a++)
                if (mem[k][a] !== word_of(10*k + a)) amis++;
        check("mem_all", 64'(amis), 64'd0);

        // Overflow while full, then clear
        send_byte(8'hAA);
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_count", 64'(byte_count), 64'd160);
        @(negedge clk);
        check("ovf_no_wr", 64'(wr_cnt - base), 64'd40);
        pulse_clear();
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_loaded", 64'(loaded), 64'd0);
        check("clr_cnt", 64'(byte_count), 64'd0);
        check("clr_state", 64'(dut.state), 64'(S_LOAD));

        // Read start outside S_FULL is ignored
        @(negedge clk); rd_start = 1'b1;
        @(negedge clk); rd_start = 1'b0;
        check("start_ign_state", 64'(dut.state), 64'(S_LOAD));

        for (int i = 0; i < 160; i++) send_byte(8'(i));
        @(negedge clk);
        check("reload", 64'(loaded), 64'd1);

        // Single-shot sweep
        @(negedge clk); rd_en = 1'b1; rd_loop = 1'b0; rd_start = 1'b1;
        @(negedge clk); rd_start = 1'b0;
        nval = 0; amis = 0; dmis = 0; first = -1; lastv = -1; done_cnt = 0; done_c = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_valid) begin
                if (first < 0) first = c;
                lastv = c;
                if (rd_addr !== 4'(nval)) amis++;
                if (rdata[31:0] !== word_of(int'(rd_addr))) dmis++;
                if (rdata[127:96] !== word_of(30 + int'(rd_addr))) dmis++;
                nval++;
            end
            if (rd_done) begin done_cnt++; done_c = c; end
        end
        check("ss_nval", 64'(nval), 64'd10);
        check("ss_first", 64'(first), 64'd0);
        check("ss_contig", 64'(lastv), 64'd9);
        check("ss_addr", 64'(amis), 64'd0);
        check("ss_data", 64'(dmis), 64'd0);
        check("ss_done_cnt", 64'(done_cnt), 64'd1);
        check("ss_done_cyc", 64'(done_c), 64'd10);
        check("ss_state", 64'(dut.state), 64'(S_FULL));

        // Looping sweep with a one-cycle enable gap, loop dropped in lap three
        @(negedge clk); rd_start = 1'b1; rd_en = 1'b1; rd_loop = 1'b1;
        nval = 0; amis = 0; first = -1; lastv = -1; done_cnt = 0; done_c = -1; gap_vld = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            rd_start = 1'b0;
            rd_en    = (c == 3) ? 1'b0 : 1'b1;
            rd_loop  = (c < 25) ? 1'b1 : 1'b0;
            if (c == 4) gap_vld = rd_valid;
            if (rd_valid) begin
                if (first < 0) first = c;
                lastv = c;
                if (rd_addr !== 4'(nval % 10)) amis++;
                nval++;
            end
            if (rd_done) begin done_cnt++; done_c = c; end
        end
        check("lp_first", 64'(first), 64'd2);
        check("lp_gap", 64'(gap_vld), 64'd0);
        check("lp_nval", 64'(nval), 64'd30);
        check("lp_addr", 64'(amis), 64'd0);
        check("lp_last", 64'(lastv), 64'd32);
        check("lp_done_cnt", 64'(done_cnt), 64'd1);
        check("lp_done_cyc", 64'(done_c), 64'd33);
        check("lp_state", 64'(dut.state), 64'(S_FULL));
        rd_en = 1'b0;

        // Clear coinciding with the word-completing byte
        pulse_clear();
        base = wr_cnt;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        @(negedge clk); rx_data = 8'h44; rx_valid = 1'b1; clear = 1'b1;
        @(negedge clk); rx_valid = 1'b0; clear = 1'b0;
        check("clrw_we", 64'(we), 64'd0);
        check("clrw_state", 64'(dut.state), 64'(S_LOAD));
        check("clrw_idx", 64'(dut.u_packer.byte_idx), 64'd0);
        check("clrw_cnt", 64'(byte_count), 64'd0);
        @(negedge clk);
        check("clrw_no_wr", 64'(wr_cnt - base), 64'd0);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        @(negedge clk);
        check("after_clr_wr_cnt", 64'(wr_cnt - base), 64'd1);
        check("after_clr_we", 64'(last_we), 64'b0001);
        check("after_clr_addr", 64'(last_addr), 64'd0);
        check("after_clr_data", 64'(last_data), 64'hD4C3B2A1);
        check("after_clr_cnt", 64'(byte_count), 64'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_bank_loader.md
Name: uart_bank_loader

Overview:
- Parametrised successor to the fixed 4-bank UART-to-BRAM fill logic in the top controller.
- Takes bytes from `uart_rx` and packs BYTES_PER_WORD bytes into one DATA_W word.
- Fills N_BANKS external single-port BRAMs sequentially, DEPTH words each.
- Once full, sweeps all banks in lock-step to stream one row per cycle to the systolic multiplier, in single-shot or looping mode, with clear/reload and overflow detection.

Parameters:
- N_BANKS, 4, number of external RAM banks (≥1).
- DEPTH, 10, words per bank (≥2).
- DATA_W, 32, RAM word width.
- BYTE_W, 8, UART byte width.
- BYTES_PER_WORD, 4, bytes packed per word; DATA_W ≥ BYTE_W*BYTES_PER_WORD, upper bits zero.
- RD_LATENCY, 1, BRAM read latency in cycles (≥1).
- AW, $clog2(DEPTH), address width.

Ports:
- i_clk  in  1  system clock (uart_clk domain).
- i_reset_n  in  1  asynchronous active-low reset.
- i_rx_data  in  BYTE_W  byte from `uart_rx`.
- i_rx_valid  in  1  level valid from `uart_rx`; block edge-detects internally.
- i_clear  in  1  sync pulse: abandon contents, restart load.
- i_rd_start  in  1  pulse: begin read sweep (honoured only in S_FULL).
- i_rd_en  in  1  sweep advance enable.
- i_rd_loop  in  1  1 = wrap sweep continuously; sampled at each wrap point.
- i_rdata  in  N_BANKS*DATA_W  concatenated bank read data, bank 0 in LSBs.
- o_we  out  N_BANKS  one-hot bank write enable.
- o_addr  out  AW  shared bank address.
- o_wdata  out  DATA_W  packed write word.
- o_rd_valid  out  1  i_rdata is a valid row this cycle.
- o_rd_addr  out  AW  row address tag aligned with o_rd_valid.
- o_rd_done  out  1  1-cycle pulse at end of single-shot sweep.
- o_loaded  out  1  all banks filled.
- o_overflow  out  1  sticky: byte arrived when not loading.
- o_byte_count  out  $clog2(N_BANKS*DEPTH*BYTES_PER_WORD+1)  bytes accepted.

Behaviour:
- **Reset** (async, i_reset_n=0): state S_LOAD; all counters 0; all outputs 0.
- **Byte accept:** on the cycle i_rx_valid rises (valid & !valid_d), the byte is accepted.
- **S_LOAD packing:**
  - Accepted byte goes into lane byte_idx; the first byte of a word occupies bits [BYTE_W-1:0].
  - byte_idx++; o_byte_count++.
  - On the accept that completes a word (byte_idx==BYTES_PER_WORD-1), the next cycle drives o_we[bank_idx]=1 for exactly 1 cycle, with o_addr=wr_addr and o_wdata=packed word.
  - wr_addr++; at DEPTH-1 it wraps to 0 and bank_idx++.
- **S_LOAD → S_FULL:** the write of bank N_BANKS-1, addr DEPTH-1 moves to S_FULL; o_loaded=1 from the following cycle.
- **Overflow:** a byte accepted in S_FULL, S_READ or S_DRAIN is discarded and sets o_overflow (sticky until clear/reset).
- **S_FULL → S_READ:** i_rd_start moves to S_READ with rd_addr=0.
- **S_READ:**
  - Each cycle with i_rd_en=1 issues rd_addr on o_addr and increments it.
  - i_rd_en=0 holds rd_addr; in-flight reads still complete.
  - On issuing DEPTH-1: if i_rd_loop=1, rd_addr wraps to 0 and the sweep stays in S_READ; else go to S_DRAIN.
- **S_DRAIN:** wait RD_LATENCY cycles, then return to S_FULL and pulse o_rd_done for 1 cycle. The sweep may be re-armed with i_rd_start.
- **Address mux:** o_addr = rd_addr in S_READ/S_DRAIN, otherwise wr_addr. o_we is never asserted outside S_LOAD.
- **Read alignment:** o_rd_valid and o_rd_addr are the issue-valid and address delayed by RD_LATENCY stages. Row data is taken directly from i_rdata.
- **Clear:**
  - i_clear in any state → S_LOAD next cycle.
  - Counters, o_loaded, o_overflow and the read pipeline valids all go to 0; RAM contents are untouched.
  - i_clear wins over a simultaneous byte accept, pending write or i_rd_start.
- **i_rd_start outside S_FULL:** ignored.
- **Partial word:** a partial word is never written; it is lost on clear.

Decomposition:
- Package uart_loader_pkg:
  - state enum {S_LOAD, S_FULL, S_READ, S_DRAIN};
  - default parameter localparams;
  - count-width function.
- One sub-module, byte_packer:
  - edge detect plus lane packing;
  - outputs a word_valid pulse and the word;
  - has its own clear input.
- Top FSM, bank/address counters and read delay line stay in uart_bank_loader.

Test Plan:
- Reset mid-load after 7 bytes → all outputs 0, state S_LOAD, next 4 bytes 0x11,0x22,0x33,0x44 write 0x44332211 to bank0 addr0.
- Stream 160 bytes (0x00..0x9F), defaults → 40 writes; bank k addr a holds bytes 4*(10k+a)..+3; o_loaded rises after the 40th write; o_byte_count=160.
- From S_FULL, send byte 0xAA → discarded, o_overflow=1, o_byte_count stays 160; i_clear → o_overflow=0, o_loaded=0, count=0.
- Single-shot read, i_rd_en=1, i_rd_loop=0 → o_rd_valid high 10 consecutive cycles, o_rd_addr 0..9 starting 1 cycle after first issue; o_rd_done pulses once, returns S_FULL.
- Looping read, toggle i_rd_en 1,0,1 → o_rd_addr sequence 0,1,(gap),2..9,0,1… continuous with no o_rd_done; drop i_rd_loop → ends after next addr 9.
- Simultaneous i_clear with 4th byte of a word → no o_we; state S_LOAD, byte_idx=0.
